// File: rtl/bank_req_ingress_pkg.sv
// Shared cross-bar types: channel count, channel id and the request record
// carried from the channel ports into the bank pipeline.
package bank_xbar_pkg;

    localparam int N_CH       = 3;
    localparam int REQ_ADDR_W = 32;
    localparam int REQ_DATA_W = 64;

    typedef logic [1:0] ch_id_t;

    typedef struct packed {
        logic [REQ_ADDR_W-1:0] addr;
        logic                  wen;
        logic [REQ_DATA_W-1:0] wdata;
        ch_id_t                ch;
    } bank_req_t;

    // Channel that follows ch in round-robin order; only 0..N_CH-1 are ever produced.
    function automatic ch_id_t nextCh(input ch_id_t ch);
        if (ch >= ch_id_t'(N_CH - 1)) begin
            return '0;
        end
        return ch + ch_id_t'(1);
    endfunction

endpackage

// File: rtl/bank_req_ingress_if.sv
// Channel-side and bank-side request signals of one bank ingress stage.
interface bank_req_ingress_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [2:0]          ch_req_valid_i;
    logic [2:0]          ch_req_ready_o;
    logic [3*ADDR_W-1:0] ch_req_addr_i;
    logic [2:0]          ch_req_wen_i;
    logic [3*DATA_W-1:0] ch_req_wdata_i;

    logic                bank_req_valid_o;
    logic                bank_req_ready_i;
    logic [1:0]          bank_req_ch_o;
    logic [ADDR_W-1:0]   bank_req_addr_o;
    logic                bank_req_wen_o;
    logic [DATA_W-1:0]   bank_req_wdata_o;
    logic [CNT_W-1:0]    fifo_cnt_o;

    modport slave (
        input  ch_req_valid_i, ch_req_addr_i, ch_req_wen_i, ch_req_wdata_i, bank_req_ready_i,
        output ch_req_ready_o, bank_req_valid_o, bank_req_ch_o, bank_req_addr_o,
               bank_req_wen_o, bank_req_wdata_o, fifo_cnt_o
    );

    modport master (
        output ch_req_valid_i, ch_req_addr_i, ch_req_wen_i, ch_req_wdata_i, bank_req_ready_i,
        input  ch_req_ready_o, bank_req_valid_o, bank_req_ch_o, bank_req_addr_o,
               bank_req_wen_o, bank_req_wdata_o, fifo_cnt_o
    );

endinterface

// File: rtl/bank_req_ingress_fifo.sv
// Generic synchronous FIFO; storage, pointers and count all clear on reset.
module bank_req_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_doPush;
    logic             w_doPop;

    assign o_full   = (r_count == CW'(DEPTH));
    assign o_empty  = (r_count == '0);
    assign o_count  = r_count;
    assign o_data   = r_mem[r_rptr];
    assign w_doPush = i_push && !o_full;
    assign w_doPop  = i_pop && !o_empty;

    // Pointers are power-of-two sized, so they wrap without explicit compare.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_doPush) begin
                r_mem[r_wptr] <= i_data;
                r_wptr        <= r_wptr + AW'(1);
            end
            if (w_doPop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/bank_req_ingress.sv
// Per-bank ingress: round-robin arbitration over the channels into a request FIFO
// that feeds the bank pipeline in arrival order.
module bank_req_ingress
    import bank_xbar_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4
) (
    input logic                clk_i,
    input logic                rst_i,
    bank_req_ingress_if.slave  bus
);

    localparam int PAY_W = ADDR_W + 1 + DATA_W + 2;
    localparam int CNT_W = $clog2(DEPTH + 1);

    ch_id_t            r_ptr;
    logic              w_grant;
    ch_id_t            w_grantCh;
    logic [2:0]        w_readyVec;
    logic [2:0]        w_scan;
    logic              w_full;
    logic              w_empty;
    logic [CNT_W-1:0]  w_count;
    logic [PAY_W-1:0]  w_pushData;
    logic [PAY_W-1:0]  w_headData;

    // Scan from the pointer; the grant depends only on valid, pointer and fill level.
    always_comb begin
        w_grant    = 1'b0;
        w_grantCh  = '0;
        w_readyVec = '0;
        w_scan     = '0;
        if (!rst_i && !w_full) begin
            for (int k = 0; k < N_CH; k++) begin
                w_scan = 3'(r_ptr) + 3'(k);
                if (w_scan >= 3'(N_CH)) begin
                    w_scan = w_scan - 3'(N_CH);
                end
                if (!w_grant && bus.ch_req_valid_i[w_scan[1:0]]) begin
                    w_grant   = 1'b1;
                    w_grantCh = w_scan[1:0];
                end
            end
        end
        if (w_grant) begin
            w_readyVec[w_grantCh] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ptr <= '0;
        end else if (w_grant) begin
            r_ptr <= nextCh(w_grantCh);
        end
    end

    assign w_pushData = {bus.ch_req_addr_i[w_grantCh*ADDR_W +: ADDR_W],
                         bus.ch_req_wen_i[w_grantCh],
                         bus.ch_req_wdata_i[w_grantCh*DATA_W +: DATA_W],
                         w_grantCh};

    bank_req_fifo #(
        .WIDTH (PAY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_push  (w_grant),
        .i_data  (w_pushData),
        .i_pop   (bus.bank_req_valid_o && bus.bank_req_ready_i),
        .o_data  (w_headData),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign bus.ch_req_ready_o   = w_readyVec;
    assign bus.bank_req_valid_o = !w_empty;
    assign bus.fifo_cnt_o       = w_count;
    assign {bus.bank_req_addr_o, bus.bank_req_wen_o, bus.bank_req_wdata_o, bus.bank_req_ch_o} = w_headData;

endmodule

// File: tb/tb_bank_req_ingress.sv
// Scoreboard bench for bank_req_ingress: an independent arbiter model predicts
// grants and queues expected heads, which are compared as the bank pops them.
module tb_bank_req_ingress;
    import bank_xbar_pkg::*;

    localparam int DEPTH = 4;

    logic clk;
    logic rst;

    bank_req_ingress_if #(.ADDR_W(REQ_ADDR_W), .DATA_W(REQ_DATA_W), .DEPTH(DEPTH)) bus ();

    bank_req_ingress #(
        .ADDR_W (REQ_ADDR_W),
        .DATA_W (REQ_DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checkCount = 0;
    int passCount  = 0;

    bank_req_t       sb[$];
    int              mPtr      = 0;
    logic            mKnown    = 1'b0;
    logic            justReset = 1'b0;
    int              mGrants   = 0;

    logic [REQ_ADDR_W-1:0] chAddr  [3];
    logic                  chWen   [3];
    logic [REQ_DATA_W-1:0] chWdata [3];

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checkCount++;
        if (obs === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] modelGrant(input logic r, input logic [2:0] v, input int ptr, input int cnt);
        if (r || cnt >= DEPTH) return 3'b000;
        for (int k = 0; k < 3; k++) begin
            int c;
            c = (ptr + k) % 3;
            if (v[c]) return 3'(1 << c);
        end
        return 3'b000;
    endfunction

    // One cycle: drive at the falling edge, compare shortly after, then advance the model
    // to account for the rising edge that follows.
    task automatic applyStimulus(input logic r, input logic [2:0] v, input logic br);
        logic [2:0] g;
        bank_req_t  e;
        @(negedge clk);
        rst = r;
        bus.ch_req_valid_i   = v;
        bus.bank_req_ready_i = br;
        for (int c = 0; c < 3; c++) begin
            bus.ch_req_addr_i[c*REQ_ADDR_W +: REQ_ADDR_W]  = chAddr[c];
            bus.ch_req_wen_i[c]                            = chWen[c];
            bus.ch_req_wdata_i[c*REQ_DATA_W +: REQ_DATA_W] = chWdata[c];
        end
        #1;
        g = modelGrant(r, v, mPtr, sb.size());
        checkOutput("ready", bus.ch_req_ready_o, g);
        if (mKnown) begin
            checkOutput("count", bus.fifo_cnt_o, sb.size());
            checkOutput("valid", bus.bank_req_valid_o, sb.size() != 0);
            if (sb.size() != 0) begin
                checkOutput("headCh",    bus.bank_req_ch_o,    sb[0].ch);
                checkOutput("headAddr",  bus.bank_req_addr_o,  sb[0].addr);
                checkOutput("headWen",   bus.bank_req_wen_o,   sb[0].wen);
                checkOutput("headWdata", bus.bank_req_wdata_o, sb[0].wdata);
            end else if (justReset) begin
                checkOutput("rstHead", {bus.bank_req_ch_o, bus.bank_req_addr_o, bus.bank_req_wen_o,
                                        bus.bank_req_wdata_o}, 0);
            end
        end
        if (r) begin
            sb.delete();
            mPtr      = 0;
            mKnown    = 1'b1;
            justReset = 1'b1;
        end else begin
            justReset = 1'b0;
            if (br && sb.size() != 0) void'(sb.pop_front());
            for (int c = 0; c < 3; c++) begin
                if (g[c]) begin
                    e.addr  = chAddr[c];
                    e.wen   = chWen[c];
                    e.wdata = chWdata[c];
                    e.ch    = ch_id_t'(c);
                    sb.push_back(e);
                    mPtr = (c + 1) % 3;
                    mGrants++;
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.ch_req_valid_i   = '0;
        bus.bank_req_ready_i = 1'b0;
        bus.ch_req_addr_i    = '0;
        bus.ch_req_wen_i     = '0;
        bus.ch_req_wdata_i   = '0;
        for (int c = 0; c < 3; c++) begin
            chAddr[c]  = 32'h1000 * (c + 1);
            chWen[c]   = 1'(c & 1);
            chWdata[c] = {32'hCAFE0000, 32'(c)};
        end

        // Reset held with every channel requesting.
        applyStimulus(1'b1, 3'b111, 1'b0);
        checkOutput("rstReady0", bus.ch_req_ready_o, 3'b000);
        applyStimulus(1'b1, 3'b111, 1'b0);
        checkOutput("rstReady1", bus.ch_req_ready_o, 3'b000);
        checkOutput("rstValid", bus.bank_req_valid_o, 1'b0);
        checkOutput("rstCount", bus.fifo_cnt_o, 0);

        // Continuous rotation from the released pointer.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 3'b111, 1'b1);
            checkOutput("rotReady", bus.ch_req_ready_o, 1 << (i % 3));
            if (i > 0) checkOutput("rotHeadCh", bus.bank_req_ch_o, (i - 1) % 3);
        end

        // Sparse: move the pointer to 1, then offer only ch0 and ch2.
        applyStimulus(1'b0, 3'b001, 1'b1);
        applyStimulus(1'b0, 3'b101, 1'b1);
        checkOutput("sparseCh2", bus.ch_req_ready_o, 3'b100);
        applyStimulus(1'b0, 3'b101, 1'b1);
        checkOutput("sparseCh0", bus.ch_req_ready_o, 3'b001);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 3'b000, 1'b1);

        // Fill to capacity from ch1 while the bank stalls.
        for (int i = 0; i < 4; i++) begin
            chAddr[1]  = 32'h100 + 32'(i);
            chWen[1]   = 1'b0;
            chWdata[1] = {$urandom, $urandom};
            applyStimulus(1'b0, 3'b010, 1'b0);
        end
        chAddr[1] = 32'h104;
        applyStimulus(1'b0, 3'b010, 1'b0);
        checkOutput("fullCount", bus.fifo_cnt_o, 4);
        checkOutput("fullReady", bus.ch_req_ready_o, 3'b000);
        applyStimulus(1'b0, 3'b010, 1'b1);
        checkOutput("fullPopReady", bus.ch_req_ready_o, 3'b000);
        applyStimulus(1'b0, 3'b010, 1'b0);
        checkOutput("afterPopCount", bus.fifo_cnt_o, 3);
        checkOutput("afterPopReady", bus.ch_req_ready_o, 3'b010);
        applyStimulus(1'b0, 3'b000, 1'b0);
        checkOutput("refillCount", bus.fifo_cnt_o, 4);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 3'b000, 1'b1);

        // Mixed traffic with the bank taking every other cycle, across pointer wrap.
        begin
            int startGrants;
            int cyc;
            startGrants = mGrants;
            cyc = 0;
            while (mGrants - startGrants < 10 && cyc < 100) begin
                logic [2:0] v;
                for (int c = 0; c < 3; c++) begin
                    chAddr[c]  = $urandom;
                    chWen[c]   = 1'($urandom_range(0, 1));
                    chWdata[c] = {$urandom, $urandom};
                end
                v = 3'($urandom_range(1, 7));
                applyStimulus(1'b0, v, 1'(cyc & 1));
                cyc++;
            end
            checkOutput("mixGrants", mGrants - startGrants, 10);
            cyc = 0;
            while (sb.size() != 0 && cyc < 20) begin
                applyStimulus(1'b0, 3'b000, 1'b1);
                cyc++;
            end
            checkOutput("mixDrained", sb.size(), 0);
        end

        // Reset while three entries are queued.
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 3'b001, 1'b0);
        applyStimulus(1'b1, 3'b000, 1'b0);
        checkOutput("midCountBefore", bus.fifo_cnt_o, 3);
        applyStimulus(1'b0, 3'b000, 1'b1);
        checkOutput("midCountAfter", bus.fifo_cnt_o, 0);
        checkOutput("midValidAfter", bus.bank_req_valid_o, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 3'b000, 1'b1);
            checkOutput("midNoStale", bus.bank_req_valid_o, 1'b0);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/bank_req_ingress.md
# bank_req_ingress

Per-bank ingress stage of the cross-bar. It takes requests from the three channels, picks one per cycle with a round-robin priority pointer, and queues the winner in a small FIFO. It presents the queued requests in order to the bank pipeline over a valid/ready handshake. It sits between the channel request ports and the bank tag/data pipeline, and exerts back-pressure on the channels when the queue is full.

## Interface
- ADDR_W, 32, request address width
- DATA_W, 64, write-data width
- DEPTH, 4, FIFO entries; power of two, ≥2
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high
- ch_req_valid_i  in  3  per-channel request valid
- ch_req_ready_o  out  3  per-channel accept; at most one bit set
- ch_req_addr_i  in  3*ADDR_W  channel c at bits [c*ADDR_W +: ADDR_W]
- ch_req_wen_i  in  3  1 = write, 0 = read
- ch_req_wdata_i  in  3*DATA_W  channel c at bits [c*DATA_W +: DATA_W]
- bank_req_valid_o  out  1  head entry valid
- bank_req_ready_i  in  1  bank accepts head
- bank_req_ch_o  out  2  source channel of head (0..2)
- bank_req_addr_o  out  ADDR_W  head address
- bank_req_wen_o  out  1  head write flag
- bank_req_wdata_o  out  DATA_W  head write data
- fifo_cnt_o  out  $clog2(DEPTH+1)  occupied entries

## Operation
- Priority pointer ptr_q is 2 bits and takes values 0..2 only; the value 3 is unreachable.
- Grant selection: scan channels ptr_q, ptr_q+1, ptr_q+2 (mod 3). The first channel with ch_req_valid_i set wins.
- A grant occurs only when the FIFO is not full (fifo_cnt_o < DEPTH) and at least one channel is valid. Its effects:
  - ch_req_ready_o sets the winner's bit (combinational).
  - The winner's payload and channel id are pushed.
  - ptr_q advances to (winner+1) mod 3 on the next cycle.
- With no grant, ch_req_ready_o is 000 and ptr_q holds.
- Full: no grant, even if a pop happens in the same cycle. There is no combinational path from bank_req_ready_i to ch_req_ready_o.
- Pop occurs when bank_req_valid_o && bank_req_ready_i; the head advances.
- Push and pop in the same cycle leave the count unchanged.
- Read/write pointers are $clog2(DEPTH) bits and wrap naturally. The count is kept separately and saturates only by construction: the stage never pushes when full and never pops when empty.
- bank_req_valid_o = (fifo_cnt_o != 0).
- Head outputs are read from storage at the read pointer. They are stable while valid && !ready, as required by the handshake rule.
- Channels must hold valid and payload until ready. This stage does not check that.

## Timing
- Reset (rst_i high at a clock edge):
  - ptr_q = 0, count = 0, read and write pointers = 0, all storage entries = 0.
  - After the edge: bank_req_valid_o = 0, bank_req_ch_o = 0, addr/wen/wdata outputs = 0, fifo_cnt_o = 0.
  - While rst_i is high, ch_req_ready_o is forced to 000.
- Reset mid-operation drops all queued entries, with no drain.
- Latency: a request granted at edge N is visible on bank_req_valid_o after edge N, assuming the FIFO was empty. It can be popped at edge N+1.
- There is no bypass path from input to output.
- Throughput is one grant per cycle and one pop per cycle.
- ch_req_ready_o depends combinationally on ch_req_valid_i, ptr_q and the count only.

## Structure
- Shared package bank_xbar_pkg holds:
  - constant N_CH = 3;
  - typedef ch_id_t (logic [1:0]);
  - typedef struct bank_req_t {addr, wen, wdata, ch}, parameterised by ADDR_W and DATA_W through the package's localparams.
- Sub-module bank_req_fifo:
  - generic synchronous FIFO with sync active-high reset;
  - push/pop/full/empty/count;
  - width and depth set by parameters.
- Arbiter and pointer logic stay in the top level.

## Test plan
- **Reset:** hold rst_i for 2 cycles with all three channels valid -> ch_req_ready_o = 000, bank_req_valid_o = 0, fifo_cnt_o = 0. The first cycle after release grants ch0.
- **Rotation:** all channels valid continuously, bank_req_ready_i = 1 -> grants ch0, ch1, ch2, ch0, … and bank_req_ch_o follows the same sequence one cycle later.
- **Sparse rotation:** ptr_q = 1 with only ch0 and ch2 valid -> ch2 granted, ptr_q becomes 0; next cycle ch0 granted.
- **Full:** bank_req_ready_i = 0, ch1 valid with addr 0x100..0x103 -> 4 grants, fifo_cnt_o = 4, then ready 000. Raise bank_req_ready_i for 1 cycle -> one pop and no push that cycle; a push in the next cycle restores count 4.
- **Ordering and wrap:** 10 mixed read/write requests pushed while popping every other cycle -> outputs match push order exactly across pointer wrap, and wen/wdata are intact.
- **Reset mid-stream:** FIFO holding 3 entries, assert rst_i -> count 0 and valid 0 next cycle; no stale entry appears after release.
